// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control and hazard unit for the 5-stage core. It carries the decoded control word
// through E/M/W and resolves miss, redirect and load-use events into stall, flush and bubble actions.
module pipe_hazard_ctrl #(
  parameter int CTRL_W     = 16,
  parameter int REG_AW     = 5,
  parameter int CNT_W      = 32,
  parameter int MISS_MAX   = 64,
  parameter int LOADUSE_EN = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_ihit,
  input  logic              i_dhit,
  input  logic              i_valid_d,
  input  logic [CTRL_W-1:0] i_ctrl_d,
  input  logic              i_mem_d,
  input  logic              i_load_d,
  input  logic [REG_AW-1:0] i_rs1_d,
  input  logic [REG_AW-1:0] i_rs2_d,
  input  logic [REG_AW-1:0] i_rd_d,
  input  logic              i_redirect_m,
  output logic [CTRL_W-1:0] o_ctrl_e,
  output logic [CTRL_W-1:0] o_ctrl_m,
  output logic [CTRL_W-1:0] o_ctrl_w,
  output logic              o_valid_e,
  output logic              o_valid_m,
  output logic              o_valid_w,
  output logic              o_stall_f,
  output logic              o_stall_d,
  output logic              o_flush_d,
  output logic [1:0]        o_state,
  output logic              o_hang,
  output logic [CNT_W-1:0]  o_stall_cnt,
  output logic [CNT_W-1:0]  o_flush_cnt
);
  localparam int WC_W = $clog2(MISS_MAX + 1);

  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_DWAIT = 2'd1, ST_IWAIT = 2'd2} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_valid_e, r_valid_m, r_valid_w;
  logic [CTRL_W-1:0] r_ctrl_e, r_ctrl_m, r_ctrl_w;
  logic              r_mem_e, r_mem_m, r_load_e;
  logic [REG_AW-1:0] r_rd_e;
  logic [WC_W-1:0]   r_wait_cnt, w_wait_nxt;
  logic              r_hang;
  logic [CNT_W-1:0]  r_stall_cnt, r_flush_cnt;

  logic w_dmiss, w_redir, w_lu, w_imiss;
  logic w_act_dmiss, w_act_redir, w_act_lu, w_act_imiss;

  assign w_dmiss = r_valid_m & r_mem_m & ~i_dhit;
  assign w_redir = r_valid_m & i_redirect_m;
  assign w_lu    = (LOADUSE_EN != 0) & r_valid_e & r_load_e & (r_rd_e != '0) & i_valid_d &
                   ((r_rd_e == i_rs1_d) | (r_rd_e == i_rs2_d));
  assign w_imiss = ~i_ihit;

  // Only the highest-priority condition acts in a cycle.
  assign w_act_dmiss = w_dmiss;
  assign w_act_redir = ~w_dmiss & w_redir;
  assign w_act_lu    = ~w_dmiss & ~w_redir & w_lu;
  assign w_act_imiss = ~w_dmiss & ~w_redir & ~w_lu & w_imiss;

  always_comb begin
    o_stall_f = 1'b0;
    o_stall_d = 1'b0;
    o_flush_d = 1'b0;
    if (i_reset) begin
      o_flush_d = 1'b1;
    end else if (w_act_dmiss || w_act_lu) begin
      o_stall_f = 1'b1;
      o_stall_d = 1'b1;
    end else if (w_act_redir) begin
      o_flush_d = 1'b1;
    end else if (w_act_imiss) begin
      o_stall_f = 1'b1;
      o_flush_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_valid_e <= 1'b0; r_valid_m <= 1'b0; r_valid_w <= 1'b0;
      r_ctrl_e  <= '0;   r_ctrl_m  <= '0;   r_ctrl_w  <= '0;
      r_mem_e   <= 1'b0; r_mem_m   <= 1'b0; r_load_e  <= 1'b0;
      r_rd_e    <= '0;
    end else if (w_act_dmiss) begin
      r_valid_w <= 1'b0;
      r_ctrl_w  <= '0;
    end else begin
      r_valid_w <= r_valid_m;
      r_ctrl_w  <= r_ctrl_m;
      if (w_act_redir) begin
        r_valid_m <= 1'b0; r_ctrl_m <= '0; r_mem_m <= 1'b0;
      end else begin
        r_valid_m <= r_valid_e; r_ctrl_m <= r_ctrl_e; r_mem_m <= r_mem_e;
      end
      // E takes D only on imiss or a normal advance; D fields are zeroed when D is empty.
      if (w_act_redir || w_act_lu) begin
        r_valid_e <= 1'b0; r_ctrl_e <= '0; r_mem_e <= 1'b0; r_load_e <= 1'b0; r_rd_e <= '0;
      end else begin
        r_valid_e <= i_valid_d;
        r_ctrl_e  <= i_valid_d ? i_ctrl_d : '0;
        r_mem_e   <= i_valid_d & i_mem_d;
        r_load_e  <= i_valid_d & i_load_d;
        r_rd_e    <= i_valid_d ? i_rd_d : '0;
      end
    end
  end

  always_comb begin
    w_state_nxt = ST_RUN;
    if (w_act_dmiss)      w_state_nxt = ST_DWAIT;
    else if (w_act_imiss) w_state_nxt = ST_IWAIT;
  end

  // wait_cnt holds the index of the current wait cycle (1 = first), restarting on a state change.
  always_comb begin
    w_wait_nxt = '0;
    if (w_state_nxt != ST_RUN) begin
      if (w_state_nxt != r_state)             w_wait_nxt = WC_W'(1);
      else if (r_wait_cnt != WC_W'(MISS_MAX)) w_wait_nxt = r_wait_cnt + WC_W'(1);
      else                                    w_wait_nxt = r_wait_cnt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_RUN;
      r_wait_cnt  <= '0;
      r_hang      <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_hang     <= r_hang | (w_wait_nxt == WC_W'(MISS_MAX));
      if ((w_act_dmiss || w_act_lu || w_act_imiss) && r_stall_cnt != '1)
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_act_redir && r_flush_cnt != '1)
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign o_ctrl_e    = r_ctrl_e;
  assign o_ctrl_m    = r_ctrl_m;
  assign o_ctrl_w    = r_ctrl_w;
  assign o_valid_e   = r_valid_e;
  assign o_valid_m   = r_valid_m;
  assign o_valid_w   = r_valid_w;
  assign o_state     = r_state;
  assign o_hang      = r_hang;
  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a table of per-cycle vectors plus hand-written
// watchdog and reset-during-miss sequences. u1 has the interlock disabled and a short watchdog.
module tb_pipe_hazard_ctrl;
  logic        clk = 1'b0;
  logic        reset, ihit, dhit, valid_d, mem_d, load_d, redirect_m;
  logic [15:0] ctrl_d;
  logic [4:0]  rs1_d, rs2_d, rd_d;

  logic [15:0] c0_e, c0_m, c0_w, c1_e, c1_m, c1_w;
  logic        v0_e, v0_m, v0_w, v1_e, v1_m, v1_w;
  logic        sf0, sd0, fd0, sf1, sd1, fd1, hang0, hang1;
  logic [1:0]  st0, st1;
  logic [31:0] scnt0, fcnt0, scnt1, fcnt1;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl u0 (
    .i_clk(clk), .i_reset(reset), .i_ihit(ihit), .i_dhit(dhit), .i_valid_d(valid_d),
    .i_ctrl_d(ctrl_d), .i_mem_d(mem_d), .i_load_d(load_d), .i_rs1_d(rs1_d), .i_rs2_d(rs2_d),
    .i_rd_d(rd_d), .i_redirect_m(redirect_m),
    .o_ctrl_e(c0_e), .o_ctrl_m(c0_m), .o_ctrl_w(c0_w), .o_valid_e(v0_e), .o_valid_m(v0_m),
    .o_valid_w(v0_w), .o_stall_f(sf0), .o_stall_d(sd0), .o_flush_d(fd0), .o_state(st0),
    .o_hang(hang0), .o_stall_cnt(scnt0), .o_flush_cnt(fcnt0));

  pipe_hazard_ctrl #(.MISS_MAX(4), .LOADUSE_EN(0)) u1 (
    .i_clk(clk), .i_reset(reset), .i_ihit(ihit), .i_dhit(dhit), .i_valid_d(valid_d),
    .i_ctrl_d(ctrl_d), .i_mem_d(mem_d), .i_load_d(load_d), .i_rs1_d(rs1_d), .i_rs2_d(rs2_d),
    .i_rd_d(rd_d), .i_redirect_m(redirect_m),
    .o_ctrl_e(c1_e), .o_ctrl_m(c1_m), .o_ctrl_w(c1_w), .o_valid_e(v1_e), .o_valid_m(v1_m),
    .o_valid_w(v1_w), .o_stall_f(sf1), .o_stall_d(sd1), .o_flush_d(fd1), .o_state(st1),
    .o_hang(hang1), .o_stall_cnt(scnt1), .o_flush_cnt(fcnt1));

  typedef struct {
    logic ihit, dhit, vd; logic [15:0] cd; logic md, ld; logic [4:0] rs1, rs2, rd; logic rdr;
    logic sf, sd, fd, ve, vm, vw; logic [15:0] cw; logic [1:0] st; int sc, fc;
  } vec_t;

  vec_t tv[41];

  function automatic vec_t mk(logic ih, logic dh, logic vd, logic [15:0] cd, logic md, logic ld,
                              logic [4:0] r1, logic [4:0] r2, logic [4:0] rd, logic rdr,
                              logic sf, logic sd, logic fd, logic ve, logic vm, logic vw,
                              logic [15:0] cw, logic [1:0] st, int sc, int fc);
    vec_t v;
    v.ihit = ih; v.dhit = dh; v.vd = vd; v.cd = cd; v.md = md; v.ld = ld;
    v.rs1 = r1; v.rs2 = r2; v.rd = rd; v.rdr = rdr;
    v.sf = sf; v.sd = sd; v.fd = fd; v.ve = ve; v.vm = vm; v.vw = vw;
    v.cw = cw; v.st = st; v.sc = sc; v.fc = fc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    ihit = 1; dhit = 1; valid_d = 0; ctrl_d = '0; mem_d = 0; load_d = 0;
    rs1_d = '0; rs2_d = '0; rd_d = '0; redirect_m = 0;
  endtask

  initial begin
    // stream, load-use, rd=0, data miss, redirect vs imiss, dmiss vs redirect
    tv[0]  = mk(1,1,1,16'h0011,0,0,0,0,0,0, 0,0,0,0,0,0,16'h0000,0,0,0);
    tv[1]  = mk(1,1,1,16'h0022,0,0,0,0,0,0, 0,0,0,1,0,0,16'h0000,0,0,0);
    tv[2]  = mk(1,1,1,16'h0033,0,0,0,0,0,0, 0,0,0,1,1,0,16'h0000,0,0,0);
    tv[3]  = mk(1,1,1,16'h0044,0,0,0,0,0,0, 0,0,0,1,1,1,16'h0011,0,0,0);
    tv[4]  = mk(1,1,0,16'h0000,0,0,0,0,0,0, 0,0,0,1,1,1,16'h0022,0,0,0);
    tv[5]  = mk(1,1,0,16'h0000,0,0,0,0,0,0, 0,0,0,0,1,1,16'h0033,0,0,0);
    tv[6]  = mk(1,1,0,16'h0000,0,0,0,0,0,0, 0,0,0,0,0,1,16'h0044,0,0,0);
    tv[7]  = mk(1,1,0,16'h0000,0,0,0,0,0,0, 0,0,0,0,0,0,16'h0000,0,0,0);
    tv[8]  = mk(1,1,1,16'h0100,1,1,0,0,5,0, 0,0,0,0,0,0,16'h0000,0,0,0);
    tv[9]  = mk(1,1,1,16'h0200,0,0,1,5,7,0, 1,1,0,1,0,0,16'h0000,0,0,0);
    tv[10] = mk(1,1,1,16'h0200,0,0,1,5,7,0, 0,0,0,0,1,0,16'h0000,0,1,0);
    tv[11] = mk(1,1,0,16'h0000,0,0,0,0,0,0, 0,0,0,1,0,1,16'h0100,0,1,0);
    tv[12] = mk(1,1,0,16'h0000,0,0,0,0,0,0, 0,0,0,0,1,0,16'h0000,0,1,0);
    tv[13] = mk(1,1,0,16'h0000,0,0,0,0,0,0, 0,0,0,0,0,1,16'h0200,0,1,0);
    tv[14] = mk(1,1,1,16'h0300,1,1,0,0,0,0, 0,0,0,0,0,0,16'h0000,0,1,0);
    tv[15] = mk(1,1,1,16'h0400,0,0,0,0,3,0, 0,0,0,1,0,0,16'h0000,0,1,0);
    tv[16] = mk(1,1,0,16'h0000,0,0,0,0,0,0, 0,0,0,1,1,0,16'h0000,0,1,0);
    tv[17] = mk(1,1,0,16'h0000,0,0,0,0,0,0, 0,0,0,0,1,1,16'h0300,0,1,0);
    tv[18] = mk(1,1,0,16'h0000,0,0,0,0,0,0, 0,0,0,0,0,1,16'h0400,0,1,0);
    tv[19] = mk(1,1,1,16'h0500,1,0,0,0,0,0, 0,0,0,0,0,0,16'h0000,0,1,0);
    tv[20] = mk(1,1,1,16'h0600,0,0,0,0,0,0, 0,0,0,1,0,0,16'h0000,0,1,0);
    tv[21] = mk(1,0,1,16'h0700,0,0,0,0,0,0, 1,1,0,1,1,0,16'h0000,0,1,0);
    tv[22] = mk(1,0,1,16'h0700,0,0,0,0,0,0, 1,1,0,1,1,0,16'h0000,1,2,0);
    tv[23] = mk(1,0,1,16'h0700,0,0,0,0,0,0, 1,1,0,1,1,0,16'h0000,1,3,0);
    tv[24] = mk(1,1,1,16'h0700,0,0,0,0,0,0, 0,0,0,1,1,0,16'h0000,1,4,0);
    tv[25] = mk(1,1,0,16'h0000,0,0,0,0,0,0, 0,0,0,1,1,1,16'h0500,0,4,0);
    tv[26] = mk(1,1,0,16'h0000,0,0,0,0,0,0, 0,0,0,0,1,1,16'h0600,0,4,0);
    tv[27] = mk(1,1,0,16'h0000,0,0,0,0,0,0, 0,0,0,0,0,1,16'h0700,0,4,0);
    tv[28] = mk(1,1,0,16'h0000,0,0,0,0,0,0, 0,0,0,0,0,0,16'h0000,0,4,0);
    tv[29] = mk(1,1,1,16'h0800,0,0,0,0,0,0, 0,0,0,0,0,0,16'h0000,0,4,0);
    tv[30] = mk(1,1,1,16'h0900,0,0,0,0,0,0, 0,0,0,1,0,0,16'h0000,0,4,0);
    tv[31] = mk(0,1,1,16'h0A00,0,0,0,0,0,1, 0,0,1,1,1,0,16'h0000,0,4,0);
    tv[32] = mk(1,1,0,16'h0000,0,0,0,0,0,0, 0,0,0,0,0,1,16'h0800,0,4,1);
    tv[33] = mk(1,1,0,16'h0000,0,0,0,0,0,0, 0,0,0,0,0,0,16'h0000,0,4,1);
    tv[34] = mk(1,1,1,16'h0B00,1,0,0,0,0,0, 0,0,0,0,0,0,16'h0000,0,4,1);
    tv[35] = mk(1,1,1,16'h0C00,0,0,0,0,0,0, 0,0,0,1,0,0,16'h0000,0,4,1);
    tv[36] = mk(1,0,0,16'h0000,0,0,0,0,0,1, 1,1,0,1,1,0,16'h0000,0,4,1);
    tv[37] = mk(1,1,0,16'h0000,0,0,0,0,0,0, 0,0,0,1,1,0,16'h0000,1,5,1);
    tv[38] = mk(1,1,0,16'h0000,0,0,0,0,0,0, 0,0,0,0,1,1,16'h0B00,0,5,1);
    tv[39] = mk(1,1,0,16'h0000,0,0,0,0,0,0, 0,0,0,0,0,1,16'h0C00,0,5,1);
    tv[40] = mk(1,1,0,16'h0000,0,0,0,0,0,0, 0,0,0,0,0,0,16'h0000,0,5,1);

    idle();
    reset = 1;
    @(negedge clk); #2;
    chk("rst flush_d", fd0, 1); chk("rst stall_f", sf0, 0); chk("rst stall_d", sd0, 0);
    @(negedge clk); #2;
    chk("rst valid_e", v0_e, 0); chk("rst valid_w", v0_w, 0); chk("rst ctrl_m", c0_m, 0);
    chk("rst state", st0, 0); chk("rst hang", hang0, 0); chk("rst stall_cnt", scnt0, 0);
    chk("rst flush_cnt", fcnt0, 0);

    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 41; i++) begin
      if (i > 0) @(negedge clk);
      ihit = tv[i].ihit; dhit = tv[i].dhit; valid_d = tv[i].vd; ctrl_d = tv[i].cd;
      mem_d = tv[i].md; load_d = tv[i].ld; rs1_d = tv[i].rs1; rs2_d = tv[i].rs2;
      rd_d = tv[i].rd; redirect_m = tv[i].rdr;
      #2;
      chk($sformatf("r%0d stall_f", i), sf0, tv[i].sf);
      chk($sformatf("r%0d stall_d", i), sd0, tv[i].sd);
      chk($sformatf("r%0d flush_d", i), fd0, tv[i].fd);
      chk($sformatf("r%0d valid_e", i), v0_e, tv[i].ve);
      chk($sformatf("r%0d valid_m", i), v0_m, tv[i].vm);
      chk($sformatf("r%0d valid_w", i), v0_w, tv[i].vw);
      chk($sformatf("r%0d ctrl_w", i), c0_w, tv[i].cw);
      chk($sformatf("r%0d state", i), st0, tv[i].st);
      chk($sformatf("r%0d stall_cnt", i), scnt0, tv[i].sc);
      chk($sformatf("r%0d flush_cnt", i), fcnt0, tv[i].fc);
      if (i == 9)  chk("nolu stall_f", sf1, 0);
      if (i == 14) chk("nolu stall_cnt", scnt1, 0);
    end

    // watchdog: 6 cycles of imiss on the short-watchdog instance
    @(negedge clk); idle(); reset = 1;
    @(negedge clk); reset = 0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      ihit = 0;
      #2;
      chk($sformatf("w%0d state", k), st1, (k == 0) ? 0 : 2);
      chk($sformatf("w%0d hang", k), hang1, (k >= 4) ? 1 : 0);
      chk($sformatf("w%0d stall_f", k), sf1, 1);
      chk($sformatf("w%0d stall_d", k), sd1, 0);
      chk($sformatf("w%0d flush_d", k), fd1, 1);
    end
    @(negedge clk); ihit = 1; #2;
    chk("wd state iwait", st1, 2); chk("wd hang held", hang1, 1);
    @(negedge clk); #2;
    chk("wd state run", st1, 0); chk("wd hang sticky", hang1, 1);
    chk("wd long hang", hang0, 0); chk("wd stall_cnt", scnt0, 6);
    @(negedge clk); reset = 1; #2;
    chk("wd rst flush_d", fd1, 1);
    @(negedge clk); #2;
    chk("wd rst hang", hang1, 0);

    // reset asserted while waiting on a data miss
    @(negedge clk); reset = 0; valid_d = 1; ctrl_d = 16'h0D00; mem_d = 1;
    @(negedge clk); idle();
    @(negedge clk); dhit = 0; #2;
    chk("rd dmiss stall_f", sf0, 1);
    @(negedge clk); #2;
    chk("rd dwait", st0, 1);
    @(negedge clk); reset = 1; #2;
    chk("rd pre stall_cnt", scnt0, 2); chk("rd pre state", st0, 1);
    chk("rd flush_d", fd0, 1); chk("rd stall_f", sf0, 0); chk("rd stall_d", sd0, 0);
    @(negedge clk); #2;
    chk("rd valid_e", v0_e, 0); chk("rd valid_m", v0_m, 0); chk("rd valid_w", v0_w, 0);
    chk("rd state", st0, 0); chk("rd stall_cnt", scnt0, 0); chk("rd flush_cnt", fcnt0, 0);
    reset = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
